// File: rtl/snn_seq_pkg.sv
// Shared types and constants for the snncore stimulus sequencer.
// The state encoding and config-bank indices are used by the top and the bench.
package snn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG_WTS,
    S_PROG_CFG,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  // Config bank order as the core expects it, written after the weights.
  localparam int CFG_VTH               = 0;
  localparam int CFG_LEAK              = 1;
  localparam int CFG_REFRAC            = 2;
  localparam int CFG_VRESET            = 3;
  localparam int CFG_SYN_DECAY         = 4;
  localparam int CFG_MODE              = 5;
  localparam int CFG_GP_SEL            = 6;
  localparam int CFG_NEURON_TO_MONITOR = 7;

  function automatic logic captures(seq_state_e s);
    return (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/snn_stim_sequencer_if.sv
// Host-side and core-side signal bundle of the stimulus sequencer.
// master = host/core environment, slave = the sequencer itself.
interface snn_stim_sequencer_if #(
  parameter int INPUT_NEURONS  = 16,
  parameter int OUTPUT_NEURONS = 8,
  parameter int GPOUT_WIDTH    = 16,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 24
);
  logic                      start;
  logic [CNT_W-1:0]          n_wts;
  logic [CNT_W-1:0]          n_steps;
  logic                      prog_valid;
  logic                      prog_ready;
  logic [ADDR_W-1:0]         prog_addr;
  logic [DATA_W-1:0]         prog_data;
  logic                      spk_valid;
  logic                      spk_ready;
  logic [INPUT_NEURONS-1:0]  spk_data;
  logic                      spk_tick;
  logic                      mem_write;
  logic                      cfg_write;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [INPUT_NEURONS-1:0]  spk_in;
  logic [OUTPUT_NEURONS-1:0] spk_out_i;
  logic [GPOUT_WIDTH-1:0]    gpout_i;
  logic                      res_valid;
  logic                      res_ready;
  logic [OUTPUT_NEURONS-1:0] res_spk;
  logic [GPOUT_WIDTH-1:0]    res_gp;
  logic                      busy;
  logic                      done;
  logic                      err_underrun;
  logic                      err_overrun;

  modport master (
    output start, n_wts, n_steps, prog_valid, prog_addr, prog_data,
           spk_valid, spk_data, spk_tick, spk_out_i, gpout_i, res_ready,
    input  prog_ready, spk_ready, mem_write, cfg_write, wr_addr, wr_data,
           spk_in, res_valid, res_spk, res_gp, busy, done, err_underrun, err_overrun
  );

  modport slave (
    input  start, n_wts, n_steps, prog_valid, prog_addr, prog_data,
           spk_valid, spk_data, spk_tick, spk_out_i, gpout_i, res_ready,
    output prog_ready, spk_ready, mem_write, cfg_write, wr_addr, wr_data,
           spk_in, res_valid, res_spk, res_gp, busy, done, err_underrun, err_overrun
  );
endinterface

// File: rtl/snn_stim_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO buffering spike vectors.
// A pop in the same cycle frees the slot, so push at full is legal alongside a pop.
module snn_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             memclk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge memclk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  // NOTE: the storage array is deliberately not reset; empty gates every read of it.
  always_ff @(posedge memclk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/snn_stim_sequencer.sv
// Programs snncore weights/config, then streams buffered spikes one per tick
// and returns captured core outputs over a valid/ready result stream.
module snn_stim_sequencer
  import snn_seq_pkg::*;
#(
  parameter int INPUT_NEURONS  = 16,
  parameter int OUTPUT_NEURONS = 8,
  parameter int GPOUT_WIDTH    = 16,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CFG_REGS       = 8,
  parameter int CNT_W          = 24,
  parameter int SPK_DEPTH      = 16,
  parameter int EXTRA_CYCLES   = 4
) (
  input logic                 memclk,
  input logic                 rst,
  snn_stim_sequencer_if.slave bus
);
  localparam int CFG_W = $clog2(CFG_REGS + 1);
  localparam int DR_W  = $clog2(EXTRA_CYCLES + 2);

  seq_state_e                state, state_nxt;
  logic [CNT_W-1:0]          n_wts_q, n_steps_q, wts_cnt, step_cnt;
  logic [CFG_W-1:0]          cfg_cnt;
  logic [DR_W-1:0]           drain_cnt;
  logic                      armed;
  logic                      mem_write, cfg_write, res_valid, err_underrun, err_overrun;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [INPUT_NEURONS-1:0]  spk_in, fifo_dout;
  logic [OUTPUT_NEURONS-1:0] res_spk;
  logic [GPOUT_WIDTH-1:0]    res_gp;
  logic launch, prog_ready, prog_acc, drain_full, tick_live;
  logic spk_ready, spk_push, spk_pop, fifo_full, fifo_empty;

  assign launch     = bus.start && (state == S_IDLE || state == S_DONE);
  assign prog_ready = (state == S_PROG_WTS) || (state == S_PROG_CFG);
  assign prog_acc   = bus.prog_valid && prog_ready;
  assign drain_full = (drain_cnt == DR_W'(EXTRA_CYCLES));
  // Once every drain sample is taken, further ticks are ignored until the last one is accepted.
  assign tick_live  = bus.spk_tick && captures(state) && !(state == S_DRAIN && drain_full);
  assign spk_pop    = tick_live && (state == S_RUN) && !fifo_empty;
  assign spk_ready  = armed && !launch && (!fifo_full || spk_pop);
  assign spk_push   = bus.spk_valid && spk_ready;

  snn_sync_fifo #(.WIDTH(INPUT_NEURONS), .DEPTH(SPK_DEPTH)) u_spk_fifo (
    .memclk(memclk), .rst(rst), .flush(launch), .push(spk_push), .din(bus.spk_data),
    .pop(spk_pop), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  // NOTE: state_nxt is defaulted before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (bus.start) state_nxt = (bus.n_wts == '0) ? S_PROG_CFG : S_PROG_WTS;
      S_PROG_WTS: if (prog_acc && wts_cnt == n_wts_q - CNT_W'(1)) state_nxt = S_PROG_CFG;
      S_PROG_CFG: if (prog_acc && cfg_cnt == CFG_W'(CFG_REGS - 1))
                    state_nxt = (n_steps_q == '0) ? S_DRAIN : S_RUN;
      S_RUN:      if (tick_live && step_cnt == n_steps_q - CNT_W'(1)) state_nxt = S_DRAIN;
      S_DRAIN:    if (drain_full && (!res_valid || bus.res_ready)) state_nxt = S_DONE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge memclk) begin
    if (rst) begin
      state        <= S_IDLE;
      n_wts_q      <= '0;
      n_steps_q    <= '0;
      wts_cnt      <= '0;
      step_cnt     <= '0;
      cfg_cnt      <= '0;
      drain_cnt    <= '0;
      armed        <= 1'b0;
      mem_write    <= 1'b0;
      cfg_write    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      spk_in       <= '0;
      res_valid    <= 1'b0;
      res_spk      <= '0;
      res_gp       <= '0;
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_write <= 1'b0;
      cfg_write <= 1'b0;
      if (launch) begin
        n_wts_q      <= bus.n_wts;
        n_steps_q    <= bus.n_steps;
        wts_cnt      <= '0;
        step_cnt     <= '0;
        cfg_cnt      <= CFG_W'(CFG_VTH);
        drain_cnt    <= '0;
        armed        <= 1'b1;
        err_underrun <= 1'b0;
        err_overrun  <= 1'b0;
      end
      if (state == S_PROG_WTS && prog_acc) begin
        mem_write <= 1'b1;
        wr_addr   <= bus.prog_addr;
        wr_data   <= bus.prog_data;
        wts_cnt   <= wts_cnt + CNT_W'(1);
      end
      if (state == S_PROG_CFG && prog_acc) begin
        cfg_write <= 1'b1;
        wr_addr   <= ADDR_W'(cfg_cnt);
        wr_data   <= bus.prog_data;
        cfg_cnt   <= cfg_cnt + CFG_W'(1);
      end
      if (tick_live) begin
        res_spk   <= bus.spk_out_i;
        res_gp    <= bus.gpout_i;
        res_valid <= 1'b1;
        if (res_valid && !bus.res_ready) err_overrun <= 1'b1;
        if (state == S_RUN) begin
          step_cnt <= step_cnt + CNT_W'(1);
          spk_in   <= fifo_empty ? '0 : fifo_dout;
          if (fifo_empty) err_underrun <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + DR_W'(1);
          spk_in    <= '0;
        end
      end else if (res_valid && bus.res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.prog_ready   = prog_ready;
  assign bus.spk_ready    = spk_ready;
  assign bus.mem_write    = mem_write;
  assign bus.cfg_write    = cfg_write;
  assign bus.wr_addr      = wr_addr;
  assign bus.wr_data      = wr_data;
  assign bus.spk_in       = spk_in;
  assign bus.res_valid    = res_valid;
  assign bus.res_spk      = res_spk;
  assign bus.res_gp       = res_gp;
  assign bus.busy         = !(state == S_IDLE || state == S_DONE);
  assign bus.done         = (state == S_DONE);
  assign bus.err_underrun = err_underrun;
  assign bus.err_overrun  = err_overrun;
endmodule
